lsu_mem_master: RTL and testbench
=================================

// Module: lsu_mem_master
// PURPOSE
//  Processor-side load/store initiator for the byte-addressed data memory (memory2c port).
//  Accepts one load/store request from the MEM stage over a valid/ready handshake.
//  Decodes RISC-V funct3 into the memory's length/sign fields and checks alignment/legality.
//  Drives the memory port for a configurable access time, then returns a single-cycle response
//  (read data or error). Sits between the pipeline MEM stage and the data memory; busy stalls the pipeline.
// PARAMETERS
//  WAIT_CYCLES  0  extra cycles the memory port is held before read data is captured (0..15)
// PORTS
//  clk           in   1   clock, posedge logic (memory writes on negedge)
//  rst           in   1   reset, synchronous, active-high
//  req_valid     in   1   pipeline request valid
//  req_ready     out  1   request accepted when valid&ready at posedge
//  req_wr        in   1   1=store, 0=load
//  req_funct3    in   3   000 b, 001 h, 010 w, 100 bu, 101 hu
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, LSB-aligned
//  resp_valid    out  1   one-cycle response pulse
//  resp_rdata    out  32  load result, extended; 0 for stores/errors
//  resp_err      out  1   misaligned or illegal access, qualified by resp_valid
//  busy          out  1   state != IDLE; pipeline stall
//  mem_addr      out  32  to memory addr
//  mem_wdata     out  32  to memory data_in
//  mem_length    out  2   00 byte, 01 half, 10 word
//  mem_sign      out  1   sign-extend loads
//  mem_enable    out  1   memory enable
//  mem_wr        out  1   memory write strobe
//  mem_rdata     in   32  from memory data_out (combinational read)
// BEHAVIOUR
//  - FSM IDLE -> ACCESS -> DONE -> IDLE; error path IDLE -> DONE.
//  - req_ready = (state==IDLE) & ~rst. No request is accepted in ACCESS or DONE; req_valid is ignored there.
//  - Accept at posedge N: latch wr, funct3, addr, wdata. Decide legality from the request:
//      - illegal: funct3 in {011,110,111}, or store with funct3[2]=1.
//      - misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
//  - Illegal or misaligned: go to DONE with err=1. mem_enable is never asserted. resp_valid is high in cycle N+1.
//  - Legal: go to ACCESS and load wait counter = WAIT_CYCLES.
//  - In ACCESS:
//      - mem_enable=1; mem_addr/mem_wdata from latches; mem_length=funct3[1:0].
//      - mem_sign = ~funct3[2] for loads, 0 for stores.
//      - Counter decrements each cycle. The final ACCESS cycle is the one with counter==0.
//      - mem_wr=1 only in the final ACCESS cycle, so exactly one negedge write per store.
//      - On the final cycle's posedge: loads capture mem_rdata into resp_rdata; stores set resp_rdata=0. Go to DONE.
//  - Timing: ACCESS spans cycles N+1..N+1+WAIT_CYCLES. resp_valid is high exactly in cycle N+2+WAIT_CYCLES.
//  - DONE: resp_valid=1 for one cycle, then IDLE. resp_rdata/resp_err hold until the next response.
//  - All mem_* outputs are 0 outside ACCESS. mem_wr is also gated by ~rst.
//  - Reset values: state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0, all mem_* 0.
//      req_ready=0 while rst is high and 1 in the cycle after release.
//  - Reset mid-operation: abort, with no resp_valid. A store aborted before its final ACCESS cycle performs no write.
//  - Back-to-back: the minimum request spacing is WAIT_CYCLES+3 cycles.
// TESTING
//  - rst high 2 cycles with req_valid=1 -> no accept; resp_valid=0, mem_enable=0; req_ready=1 the cycle after release.
//  - W=0: sw 0x100 data 0xDEADBEEF at N -> mem_wr high only in N+1, resp_valid in N+2, err=0.
//      Then lw 0x100 -> resp_rdata=0xDEADBEEF.
//  - After that store:
//      - lb 0x103 -> 0xFFFFFFDE; lbu 0x103 -> 0x000000DE.
//      - lh 0x102 -> 0xFFFFDEAD; lhu 0x102 -> 0x0000DEAD.
//  - lw 0x102, sh 0x101, funct3=011, sb with funct3=100 -> each resp_valid at N+1 with resp_err=1 and rdata=0.
//      mem_enable stays 0 throughout.
//  - W=3: lw -> mem_enable high cycles N+1..N+4, resp_valid at N+5. req_valid held during busy is not accepted.
//      sw -> mem_wr high only in N+4.
//  - W=3: sw 0x200 0x12345678, rst pulsed in N+2 -> no resp_valid and no write; a later lw 0x200 returns 0x00000000.

Source files
------------

// File: rtl/lsu_mem_master_if.sv
// Bundles the pipeline request/response and memory-port signals of the load/store initiator.
// master = the initiator; slave = pipeline plus data memory.
interface lsu_mem_master_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_length;
   logic        mem_sign;
   logic        mem_enable;
   logic        mem_wr;
   logic [31:0] mem_rdata;

   modport master (
      input  req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy,
             mem_addr, mem_wdata, mem_length, mem_sign, mem_enable, mem_wr
   );

   modport slave (
      output req_valid, req_wr, req_funct3, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy,
             mem_addr, mem_wdata, mem_length, mem_sign, mem_enable, mem_wr
   );
endinterface

// File: rtl/lsu_mem_master.sv
// Load/store initiator: response WAIT_CYCLES+2 cycles after accept (1 cycle on error).
// One request in flight; req_ready is low whenever not IDLE, so busy stalls the MEM stage.
module lsu_mem_master #(
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic            clk,
   input  logic            rst,
   lsu_mem_master_if.master bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        wr_q, wr_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic accept;
   logic illegal;
   logic misaligned;
   logic in_access;
   logic final_cycle;

   assign accept      = bus.req_valid & bus.req_ready;
   assign illegal     = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                        (bus.req_wr && bus.req_funct3[2]);
   assign misaligned  = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
   assign in_access   = (state_q == ACCESS);
   assign final_cycle = in_access && (cnt_q == 4'd0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      funct3_d = funct3_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               wr_d     = bus.req_wr;
               funct3_d = bus.req_funct3;
               addr_d   = bus.req_addr;
               wdata_d  = bus.req_wdata;
               if (illegal || misaligned) begin
                  // Bad requests never touch the memory port.
                  state_d = DONE;
                  err_d   = 1'b1;
                  rdata_d = 32'h0;
               end else begin
                  state_d = ACCESS;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         ACCESS: begin
            if (cnt_q == 4'd0) begin
               state_d = DONE;
               err_d   = 1'b0;
               rdata_d = wr_q ? 32'h0 : bus.mem_rdata;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         wr_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wr_q     <= wr_d;
         funct3_q <= funct3_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign bus.busy       = (state_q != IDLE);
   assign bus.resp_valid = (state_q == DONE);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   // The memory writes on negedge, so the strobe is confined to the final cycle and dropped under reset.
   assign bus.mem_enable = in_access;
   assign bus.mem_addr   = in_access ? addr_q : 32'h0;
   assign bus.mem_wdata  = in_access ? wdata_q : 32'h0;
   assign bus.mem_length = in_access ? funct3_q[1:0] : 2'b00;
   assign bus.mem_sign   = in_access && !wr_q && !funct3_q[2];
   assign bus.mem_wr     = final_cycle && wr_q && !rst;
endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: two instances (WAIT_CYCLES 0 and 3), each with a byte memory behind it.
module tb_lsu_mem_master;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req_valid [2];
   logic        req_wr [2];
   logic [2:0]  req_funct3 [2];
   logic [31:0] req_addr [2];
   logic [31:0] req_wdata [2];
   logic        req_ready_o [2];
   logic        resp_valid_o [2];
   logic [31:0] resp_rdata_o [2];
   logic        resp_err_o [2];
   logic        busy_o [2];
   logic [31:0] mem_addr_o [2];
   logic [31:0] mem_wdata_o [2];
   logic [1:0]  mem_length_o [2];
   logic        mem_sign_o [2];
   logic        mem_enable_o [2];
   logic        mem_wr_o [2];

   for (genvar g = 0; g < 2; g++) begin : gd
      lsu_mem_master_if bus ();
      logic [7:0]  mem [4096] = '{default: 8'h00};
      logic [11:0] ma;
      logic [31:0] mword;

      assign bus.req_valid  = req_valid[g];
      assign bus.req_wr     = req_wr[g];
      assign bus.req_funct3 = req_funct3[g];
      assign bus.req_addr   = req_addr[g];
      assign bus.req_wdata  = req_wdata[g];
      assign req_ready_o[g]  = bus.req_ready;
      assign resp_valid_o[g] = bus.resp_valid;
      assign resp_rdata_o[g] = bus.resp_rdata;
      assign resp_err_o[g]   = bus.resp_err;
      assign busy_o[g]       = bus.busy;
      assign mem_addr_o[g]   = bus.mem_addr;
      assign mem_wdata_o[g]  = bus.mem_wdata;
      assign mem_length_o[g] = bus.mem_length;
      assign mem_sign_o[g]   = bus.mem_sign;
      assign mem_enable_o[g] = bus.mem_enable;
      assign mem_wr_o[g]     = bus.mem_wr;

      lsu_mem_master #(.WAIT_CYCLES(g * 3)) dut (.clk(clk), .rst(rst), .bus(bus.master));

      // Memory stand-in: combinational read with extension, negedge write.
      assign ma    = bus.mem_addr[11:0];
      assign mword = {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
      always_comb begin
         case (bus.mem_length)
            2'b00:   bus.mem_rdata = bus.mem_sign ? {{24{mword[7]}}, mword[7:0]} : {24'h0, mword[7:0]};
            2'b01:   bus.mem_rdata = bus.mem_sign ? {{16{mword[15]}}, mword[15:0]} : {16'h0, mword[15:0]};
            default: bus.mem_rdata = mword;
         endcase
      end
      always @(negedge clk) begin
         if (bus.mem_enable && bus.mem_wr) begin
            for (int i = 0; i < 4; i++)
               if (i == 0 || (i == 1 && bus.mem_length != 2'b00) || bus.mem_length == 2'b10)
                  mem[ma + 12'(i)] = bus.mem_wdata[8*i +: 8];
         end
      end
   end

   typedef struct {
      int          g;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t        tab [14];
   logic [7:0]  ref_mem [2][4096];
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", nm, got, exp);
   endtask

   // Reference: architectural effect of one access on a flat byte memory.
   task automatic model(input int g, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
      int nbytes;
      logic [31:0] v;
      nbytes = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (wr && f3[2]) || ((addr % nbytes) != 0);
      rdata = 32'h0;
      if (!err) begin
         if (wr) begin
            for (int i = 0; i < nbytes; i++)
               ref_mem[g][int'((addr + i) & 32'hFFF)] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nbytes; i++)
               v = v | (32'(ref_mem[g][int'((addr + i) & 32'hFFF)]) << (8 * i));
            if (!f3[2] && v[8*nbytes-1] && nbytes < 4)
               v = v | (32'hFFFF_FFFF << (8 * nbytes));
            rdata = v;
         end
      end
   endtask

   // Issues one request (held until the response), checking cycle-by-cycle timing. Starts/ends at a negedge.
   task automatic do_req(input int g, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic use_model, input logic [31:0] tab_rdata,
                         input logic tab_err, input string nm);
      logic        m_err, exp_err, exp_en, exp_wr;
      logic [31:0] m_rdata, exp_rdata, got_rdata;
      logic        got_err;
      int          w, rc, bad_en, bad_wr, bad_rv, bad_rdy, bad_fld;
      w = (g == 0) ? 0 : 3;
      model(g, wr, f3, addr, wdata, m_err, m_rdata);
      exp_rdata = use_model ? m_rdata : tab_rdata;
      exp_err   = use_model ? m_err : tab_err;
      rc = exp_err ? 1 : 2 + w;
      check({nm, "_ready_idle"}, 32'(req_ready_o[g]), 32'd1);
      req_valid[g] = 1'b1; req_wr[g] = wr; req_funct3[g] = f3; req_addr[g] = addr; req_wdata[g] = wdata;
      bad_en = 0; bad_wr = 0; bad_rv = 0; bad_rdy = 0; bad_fld = 0;
      got_rdata = 32'hX; got_err = 1'bX;
      for (int k = 1; k <= w + 4; k++) begin
         @(negedge clk);
         exp_en = !exp_err && (k <= 1 + w);
         exp_wr = exp_en && wr && (k == 1 + w);
         if (mem_enable_o[g] !== exp_en) bad_en++;
         if (mem_wr_o[g] !== exp_wr) bad_wr++;
         if (resp_valid_o[g] !== (k == rc)) bad_rv++;
         if (req_ready_o[g] !== (k > rc) || busy_o[g] !== (k <= rc)) bad_rdy++;
         if (exp_en) begin
            if (mem_addr_o[g] !== addr || mem_wdata_o[g] !== wdata || mem_length_o[g] !== f3[1:0] ||
                mem_sign_o[g] !== (!wr && !f3[2])) bad_fld++;
         end else if (mem_addr_o[g] !== 32'h0 || mem_wdata_o[g] !== 32'h0 ||
                      mem_length_o[g] !== 2'b00 || mem_sign_o[g] !== 1'b0) bad_fld++;
         if (k == rc) begin
            got_rdata = resp_rdata_o[g];
            got_err   = resp_err_o[g];
            req_valid[g] = 1'b0;
         end
      end
      check({nm, "_en_cycles_bad"}, bad_en, 0);
      check({nm, "_wr_cycles_bad"}, bad_wr, 0);
      check({nm, "_rv_cycles_bad"}, bad_rv, 0);
      check({nm, "_rdy_busy_bad"}, bad_rdy, 0);
      check({nm, "_memfield_bad"}, bad_fld, 0);
      check({nm, "_rdata"}, got_rdata, exp_rdata);
      check({nm, "_err"}, 32'(got_err), 32'(exp_err));
      check({nm, "_rdata_hold"}, resp_rdata_o[g], exp_rdata);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int seen_rv, seen_wr;
      for (int g = 0; g < 2; g++)
         for (int i = 0; i < 4096; i++) ref_mem[g][i] = 8'h00;
      tab[0]  = '{0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0};
      tab[1]  = '{0, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1'b0};
      tab[2]  = '{0, 1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFFDE, 1'b0};
      tab[3]  = '{0, 1'b0, 3'b100, 32'h103, 32'h0,        32'h000000DE, 1'b0};
      tab[4]  = '{0, 1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFFDEAD, 1'b0};
      tab[5]  = '{0, 1'b0, 3'b101, 32'h102, 32'h0,        32'h0000DEAD, 1'b0};
      tab[6]  = '{0, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        1'b1};
      tab[7]  = '{0, 1'b1, 3'b001, 32'h101, 32'h1234,     32'h0,        1'b1};
      tab[8]  = '{0, 1'b0, 3'b011, 32'h100, 32'h0,        32'h0,        1'b1};
      tab[9]  = '{0, 1'b1, 3'b100, 32'h100, 32'h55,       32'h0,        1'b1};
      tab[10] = '{1, 1'b1, 3'b010, 32'h180, 32'hCAFEF00D, 32'h0,        1'b0};
      tab[11] = '{1, 1'b0, 3'b010, 32'h180, 32'h0,        32'hCAFEF00D, 1'b0};
      tab[12] = '{1, 1'b0, 3'b000, 32'h181, 32'h0,        32'hFFFFFFF0, 1'b0};
      tab[13] = '{1, 1'b0, 3'b101, 32'h182, 32'h0,        32'h0000CAFE, 1'b0};

      // Reset held two cycles with a request pending.
      rst = 1'b1;
      for (int g = 0; g < 2; g++) begin
         req_valid[g] = 1'b1; req_wr[g] = 1'b0; req_funct3[g] = 3'b010;
         req_addr[g] = 32'h100; req_wdata[g] = 32'h0;
      end
      repeat (2) begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            check("rst_ready", 32'(req_ready_o[g]), 32'd0);
            check("rst_resp_valid", 32'(resp_valid_o[g]), 32'd0);
            check("rst_mem_enable", 32'(mem_enable_o[g]), 32'd0);
         end
      end
      rst = 1'b0;
      for (int g = 0; g < 2; g++) req_valid[g] = 1'b0;
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("post_rst_ready", 32'(req_ready_o[g]), 32'd1);
         check("post_rst_busy", 32'(busy_o[g]), 32'd0);
         check("post_rst_rdata", resp_rdata_o[g], 32'h0);
         check("post_rst_err", 32'(resp_err_o[g]), 32'd0);
         check("post_rst_mem_wr", 32'(mem_wr_o[g]), 32'd0);
      end

      for (int i = 0; i < 14; i++)
         do_req(tab[i].g, tab[i].wr, tab[i].f3, tab[i].addr, tab[i].wdata, 1'b0,
                tab[i].exp_rdata, tab[i].exp_err, $sformatf("vec%0d", i));

      // W=3 store aborted by reset in its second access cycle.
      req_valid[1] = 1'b1; req_wr[1] = 1'b1; req_funct3[1] = 3'b010;
      req_addr[1] = 32'h200; req_wdata[1] = 32'h12345678;
      @(negedge clk);
      check("abort_accepted_busy", 32'(busy_o[1]), 32'd1);
      req_valid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      seen_rv = 0; seen_wr = 0;
      for (int k = 3; k <= 10; k++) begin
         @(negedge clk);
         if (k == 3) check("abort_rst_ready", 32'(req_ready_o[1]), 32'd0);
         rst = 1'b0;
         if (resp_valid_o[1] === 1'b1) seen_rv++;
         if (mem_wr_o[1] === 1'b1) seen_wr++;
      end
      check("abort_resp_valid_seen", seen_rv, 0);
      check("abort_mem_wr_seen", seen_wr, 0);
      check("abort_busy", 32'(busy_o[1]), 32'd0);
      do_req(1, 1'b0, 3'b010, 32'h200, 32'h0, 1'b0, 32'h0, 1'b0, "abort_lw");

      // Random traffic against the reference model.
      for (int i = 0; i < 60; i++) begin
         int g;
         logic wr;
         logic [2:0] f3;
         g  = int'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
         else if (wr) f3 = 3'($urandom_range(0, 2));
         else begin
            f3 = 3'($urandom_range(0, 4));
            if (f3 == 3'd3) f3 = 3'd5;
         end
         do_req(g, wr, f3, 32'h300 + $urandom_range(0, 15), $urandom, 1'b1, 32'h0, 1'b0,
                $sformatf("rnd%0d", i));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
